matvec_seq: RTL and testbench

Parametrised sequential N x N matrix times N x 1 vector multiplier for the pixel transform path. It replaces the fixed 4x4 combinational multiply with a resident coefficient matrix, a valid/ready vector input and a valid/ready result output. It runs one column per cycle using N row-parallel multiply-accumulate lanes. Operands are unsigned or signed depending on a mode parameter.

---
 rtl/matvec_if.sv | 32 +++
 rtl/matvec_seq.sv | 115 +++++++++++
 tb/tb_matvec_seq.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/matvec_if.sv
// Bus bundle for matvec_seq: coefficient write port, vector input handshake,
// result output handshake, and status/debug observation.
interface matvec_if #(
    parameter int N     = 4,
    parameter int LOG2N = 2,
    parameter int DW    = 16,
    parameter int AW    = 32
);
    logic                 mat_we;
    logic [2*LOG2N-1:0]   mat_addr;
    logic [DW-1:0]        mat_wdata;
    logic                 vec_valid;
    logic                 vec_ready;
    logic [N*DW-1:0]      vec_data;
    logic                 res_valid;
    logic                 res_ready;
    logic [N*AW-1:0]      res_data;
    logic                 busy;
    logic [1:0]           dbg_state;

    // Handshakes: a transfer happens on a rising clk edge where valid && ready;
    // the source keeps valid and data stable until that edge.
    modport master (
        output mat_we, mat_addr, mat_wdata, vec_valid, vec_data, res_ready,
        input  vec_ready, res_valid, res_data, busy, dbg_state
    );

    modport slave (
        input  mat_we, mat_addr, mat_wdata, vec_valid, vec_data, res_ready,
        output vec_ready, res_valid, res_data, busy, dbg_state
    );
endinterface

// File: rtl/matvec_seq.sv
// Sequential N x N matrix times vector: resident coefficient RAM, one column per
// cycle across N row-parallel MAC lanes, valid/ready in and out.
module matvec_seq #(
    parameter int N      = 4,
    parameter int LOG2N  = 2,
    parameter int DW     = 16,
    parameter int AW     = 32,
    parameter int SIGNED = 0
) (
    input  logic     clk,
    input  logic     reset,
    matvec_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [DW-1:0]    r_mat [0:N-1][0:N-1];
    logic [DW-1:0]    r_vec [0:N-1];
    logic [AW-1:0]    r_acc [0:N-1];
    logic [AW-1:0]    w_acc_next [0:N-1];
    logic [LOG2N-1:0] r_col;
    logic [N*AW-1:0]  r_res;
    logic [LOG2N-1:0] w_row_idx;
    logic [LOG2N-1:0] w_col_idx;
    logic             w_wr_ok;
    logic             w_accept;
    logic             w_last;
    logic             w_vec_ready;
    logic             w_res_valid;
    logic             w_busy;

    function automatic logic [AW-1:0] ext(input logic [DW-1:0] x);
        if (SIGNED != 0) return {{(AW-DW){x[DW-1]}}, x};
        else             return {{(AW-DW){1'b0}}, x};
    endfunction

    assign w_row_idx = bus.mat_addr[2*LOG2N-1 -: LOG2N];
    assign w_col_idx = bus.mat_addr[LOG2N-1:0];
    // Coefficients are frozen outside IDLE so a running product sees one matrix.
    assign w_wr_ok   = bus.mat_we && (r_state == S_IDLE)
                       && ({1'b0, w_row_idx} < (LOG2N+1)'(N))
                       && ({1'b0, w_col_idx} < (LOG2N+1)'(N));
    assign w_accept  = w_vec_ready && bus.vec_valid;
    assign w_last    = (r_col == LOG2N'(N-1));

    always_comb begin
        w_next      = r_state;
        w_vec_ready = 1'b0;
        w_res_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_vec_ready = 1'b1;
                if (bus.vec_valid) w_next = S_MAC;
            end
            S_MAC: begin
                w_busy = 1'b1;
                if (w_last) w_next = S_OUT;
            end
            S_OUT: begin
                w_busy      = 1'b1;
                w_res_valid = 1'b1;
                if (bus.res_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        for (int r = 0; r < N; r++) begin
            w_acc_next[r] = r_acc[r] + ext(r_mat[r][r_col]) * ext(r_vec[r_col]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_res   <= '0;
            for (int r = 0; r < N; r++) begin
                r_vec[r] <= '0;
                r_acc[r] <= '0;
                for (int c = 0; c < N; c++) r_mat[r][c] <= '0;
            end
        end else begin
            r_state <= w_next;
            if (w_wr_ok) r_mat[w_row_idx][w_col_idx] <= bus.mat_wdata;
            if (w_accept) begin
                for (int k = 0; k < N; k++) begin
                    r_vec[k] <= bus.vec_data[k*DW +: DW];
                    r_acc[k] <= '0;
                end
                r_col <= '0;
            end
            if (r_state == S_MAC) begin
                r_col <= r_col + LOG2N'(1);
                for (int r = 0; r < N; r++) begin
                    r_acc[r] <= w_acc_next[r];
                    if (w_last) r_res[r*AW +: AW] <= w_acc_next[r];
                end
            end
        end
    end

    assign bus.vec_ready = w_vec_ready;
    assign bus.res_valid = w_res_valid;
    assign bus.busy      = w_busy;
    assign bus.res_data  = r_res;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_matvec_seq.sv
// Bench for matvec_seq: an unsigned and a signed instance share the same
// stimulus; table vectors plus hand-written backpressure/write/reset sequences.
module tb_matvec_seq;
    localparam int N = 4, LOG2N = 2, DW = 16, AW = 32;

    typedef struct packed {
        logic [0:3][0:3][15:0] m;
        logic [0:3][15:0]      v;
        logic [0:3][31:0]      eu;
        logic [0:3][31:0]      es;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mat_we;
    logic [3:0]  mat_addr;
    logic [15:0] mat_wdata;
    logic        vec_valid;
    logic [63:0] vec_data;
    logic        res_ready;

    logic [31:0] exp_u_q[$];
    logic [31:0] exp_s_q[$];
    rec_t        tbl [5];
    int          n_pass  = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    matvec_if #(.N(N), .LOG2N(LOG2N), .DW(DW), .AW(AW)) u_if ();
    matvec_if #(.N(N), .LOG2N(LOG2N), .DW(DW), .AW(AW)) s_if ();

    assign u_if.mat_we    = mat_we;
    assign u_if.mat_addr  = mat_addr;
    assign u_if.mat_wdata = mat_wdata;
    assign u_if.vec_valid = vec_valid;
    assign u_if.vec_data  = vec_data;
    assign u_if.res_ready = res_ready;
    assign s_if.mat_we    = mat_we;
    assign s_if.mat_addr  = mat_addr;
    assign s_if.mat_wdata = mat_wdata;
    assign s_if.vec_valid = vec_valid;
    assign s_if.vec_data  = vec_data;
    assign s_if.res_ready = res_ready;

    matvec_seq #(.N(N), .LOG2N(LOG2N), .DW(DW), .AW(AW), .SIGNED(0)) u_dut (
        .clk(clk), .reset(reset), .bus(u_if)
    );
    matvec_seq #(.N(N), .LOG2N(LOG2N), .DW(DW), .AW(AW), .SIGNED(1)) s_dut (
        .clk(clk), .reset(reset), .bus(s_if)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mat(input logic [0:3][0:3][15:0] m);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                mat_we    = 1'b1;
                mat_addr  = 4'(r*4 + c);
                mat_wdata = m[r][c];
                tick();
            end
        end
        mat_we = 1'b0;
    endtask

    task automatic push_exp(input logic [0:3][31:0] eu, input logic [0:3][31:0] es);
        for (int k = 0; k < N; k++) begin
            exp_u_q.push_back(eu[k]);
            exp_s_q.push_back(es[k]);
        end
    endtask

    task automatic send_vec(input logic [0:3][15:0] v);
        for (int k = 0; k < N; k++) vec_data[k*16 +: 16] = v[k];
        chk("accept_ready", 32'(u_if.vec_ready), 32'd1);
        vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
    endtask

    task automatic wait_lat(input string tag, input int exp_lat);
        int lat = 0;
        while (!u_if.res_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_s_valid"}, 32'(s_if.res_valid), 32'd1);
    endtask

    task automatic collect(input string tag);
        logic [31:0] e;
        chk({tag, "_valid"}, 32'(u_if.res_valid), 32'd1);
        for (int r = 0; r < N; r++) begin
            if (exp_u_q.size() == 0 || exp_s_q.size() == 0) begin
                n_total++;
                $display("FAIL %s_queue: expected queue empty at row %0d", tag, r);
            end else begin
                e = exp_u_q.pop_front();
                chk($sformatf("%s_u_row%0d", tag, r), u_if.res_data[r*32 +: 32], e);
                e = exp_s_q.pop_front();
                chk($sformatf("%s_s_row%0d", tag, r), s_if.res_data[r*32 +: 32], e);
            end
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(u_if.res_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(u_if.vec_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:3][31:0] e0;
        logic [0:3][31:0] e1;
        logic [0:3][31:0] ez;
        int seen;
        int d;

        tbl[0].m = '{'{16'd1, 16'd1, 16'd2, 16'd3}, '{16'd5, 16'd6, 16'd7, 16'd3},
                     '{16'd1, 16'd2, 16'd3, 16'd2}, '{16'd4, 16'd5, 16'd3, 16'd5}};
        tbl[0].v  = '{16'd2, 16'd5, 16'd3, 16'd1};
        tbl[0].eu = '{32'd16, 32'd64, 32'd23, 32'd47};
        tbl[0].es = '{32'd16, 32'd64, 32'd23, 32'd47};
        tbl[1].m  = '0;
        tbl[1].m[0][0] = 16'hFFFF;
        tbl[1].v  = '{16'd3, 16'd0, 16'd0, 16'd0};
        tbl[1].eu = '{32'h0002FFFD, 32'd0, 32'd0, 32'd0};
        tbl[1].es = '{32'hFFFFFFFD, 32'd0, 32'd0, 32'd0};
        tbl[2].m  = '1;
        tbl[2].v  = '1;
        tbl[2].eu = '{32'hFFF80004, 32'hFFF80004, 32'hFFF80004, 32'hFFF80004};
        tbl[2].es = '{32'd4, 32'd4, 32'd4, 32'd4};
        tbl[3].m  = '0;
        tbl[3].m[0][0] = 16'hFFFE;
        tbl[3].m[0][1] = 16'd2;
        tbl[3].v  = '{16'd5, 16'hFFFF, 16'd0, 16'd0};
        tbl[3].eu = '{32'h0006FFF4, 32'd0, 32'd0, 32'd0};
        tbl[3].es = '{32'hFFFFFFF4, 32'd0, 32'd0, 32'd0};
        tbl[4].m  = '0;
        for (int r = 0; r < N; r++) begin
            d = $urandom_range(1, 255);
            tbl[4].m[r][r] = 16'(d);
            tbl[4].v[r]    = 16'($urandom_range(0, 255));
            tbl[4].eu[r]   = 32'(d) * 32'(tbl[4].v[r]);
            tbl[4].es[r]   = tbl[4].eu[r];
        end

        reset = 1'b1; mat_we = 1'b0; mat_addr = '0; mat_wdata = '0;
        vec_valid = 1'b0; vec_data = '0; res_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_vec_ready", 32'(u_if.vec_ready), 32'd1);
        chk("rst_res_valid", 32'(u_if.res_valid), 32'd0);
        chk("rst_busy",      32'(u_if.busy), 32'd0);
        chk("rst_state",     32'(u_if.dbg_state), 32'd0);
        chk("rst_res_lo",    u_if.res_data[31:0], 32'd0);
        chk("rst_res_hi",    s_if.res_data[127:96], 32'd0);

        for (int i = 0; i < 5; i++) begin
            load_mat(tbl[i].m);
            push_exp(tbl[i].eu, tbl[i].es);
            send_vec(tbl[i].v);
            wait_lat($sformatf("vec%0d", i), 4);
            collect($sformatf("vec%0d", i));
        end

        e0 = '{32'd16, 32'd64, 32'd23, 32'd47};
        e1 = '{32'd32, 32'd64, 32'd23, 32'd47};
        ez = '0;
        load_mat(tbl[0].m);

        // Backpressure with a second vector waiting on the input.
        push_exp(e0, e0);
        for (int k = 0; k < N; k++) vec_data[k*16 +: 16] = tbl[0].v[k];
        vec_valid = 1'b1;
        tick();
        vec_data = 64'h0009_0008_0007_0006;
        wait_lat("bp", 4);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_valid_c%0d", c), 32'(u_if.res_valid), 32'd1);
            chk($sformatf("bp_vready_c%0d", c), 32'(u_if.vec_ready), 32'd0);
            chk($sformatf("bp_row0_c%0d", c), u_if.res_data[31:0], 32'd16);
            chk($sformatf("bp_row3_c%0d", c), u_if.res_data[127:96], 32'd47);
            tick();
        end
        vec_valid = 1'b0;
        collect("bp");
        chk("bp_no_accept", 32'(u_if.busy), 32'd0);

        // Write during MAC is dropped; the result and the next one use the old coefficient.
        push_exp(e0, e0);
        send_vec(tbl[0].v);
        mat_we = 1'b1; mat_addr = 4'd0; mat_wdata = 16'd9;
        tick();
        mat_we = 1'b0;
        wait_lat("mac_wr", 3);
        collect("mac_wr");
        push_exp(e0, e0);
        send_vec(tbl[0].v);
        wait_lat("mac_wr_next", 4);
        collect("mac_wr_next");

        mat_we = 1'b1; mat_addr = 4'd0; mat_wdata = 16'd9;
        tick();
        mat_we = 1'b0;
        push_exp(e1, e1);
        send_vec(tbl[0].v);
        wait_lat("idle_wr", 4);
        collect("idle_wr");

        // Write and vector accept on the same edge: the MAC sees the new value.
        mat_we = 1'b1; mat_addr = 4'd0; mat_wdata = 16'd1;
        push_exp(e0, e0);
        send_vec(tbl[0].v);
        mat_we = 1'b0;
        wait_lat("same_wr", 4);
        collect("same_wr");

        // Reset in the second MAC cycle discards the product and clears the matrix.
        send_vec(tbl[0].v);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_state", 32'(u_if.dbg_state), 32'd0);
        chk("mrst_valid", 32'(u_if.res_valid), 32'd0);
        chk("mrst_busy",  32'(u_if.busy), 32'd0);
        chk("mrst_ready", 32'(s_if.vec_ready), 32'd1);
        seen = 0;
        repeat (8) begin
            if (u_if.res_valid || s_if.res_valid) seen++;
            tick();
        end
        chk("mrst_no_valid", 32'(seen), 32'd0);
        push_exp(ez, ez);
        send_vec(tbl[0].v);
        wait_lat("after_rst", 4);
        collect("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
